// File: rtl/alu4_sequencer.sv
// -----------------------------------------------------------------------------
// alu4_sequencer
//
// Command-side controller for an external 4-bit ALU core. It keeps a 4x4-bit
// register file and a 4-bit flag register {ovf, zero, rc, c}, and accepts
// register-addressed ALU commands over a valid/ready handshake. For each
// command the sequencer:
//   1. presents the operands, opcode and carries on the alu_* outputs,
//   2. holds them stable for ALU_LAT cycles,
//   3. samples the ALU result and flags,
//   4. writes them back and returns a response.
// Chain mode takes the carries from the flag register, which lets software
// build multi-nibble adds and rotates.
//
// Parameters
//   ALU_LAT   cycles the ALU inputs are held before sampling (1..15)
//   FLAG_RST  reset value of the flag register {ovf, zero, rc, c}
//
// Ports
//   clk, rst                   rising-edge clock, async active-high reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_op/srca/srcb/dst       opcode and register indices
//   cmd_chain/cin/rcin         carry source select and explicit carries
//   ld_valid/ld_dst/ld_data    immediate register load (any state)
//   alu_op/a/b/cin/rcin        registered drive to the ALU core
//   alu_out/cout/rcout/ovf/zero  ALU core results
//   rsp_valid/rsp_ready        response handshake
//   rsp_data/rsp_flags         captured result and {ovf, zero, rc, c}
//   rd_sel/rd_data             combinational debug read of the register file
// -----------------------------------------------------------------------------
module alu4_sequencer #(
    parameter int unsigned ALU_LAT  = 1,
    parameter logic [3:0]  FLAG_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [1:0] cmd_srca,
    input  logic [1:0] cmd_srcb,
    input  logic [1:0] cmd_dst,
    input  logic       cmd_chain,
    input  logic       cmd_cin,
    input  logic       cmd_rcin,
    input  logic       ld_valid,
    input  logic [1:0] ld_dst,
    input  logic [3:0] ld_data,
    output logic [3:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    output logic       alu_rcin,
    input  logic [3:0] alu_out,
    input  logic       alu_cout,
    input  logic       alu_rcout,
    input  logic       alu_ovf,
    input  logic       alu_zero,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic [3:0] rsp_flags,
    input  logic [1:0] rd_sel,
    output logic [3:0] rd_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Counter preload: the capture edge is ALU_LAT edges after the accept edge.
    localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

    state_t     state_q,     state_d;
    logic [3:0] cnt_q,       cnt_d;
    logic [1:0] dst_q,       dst_d;
    logic [3:0] flags_q,     flags_d;
    logic [3:0] rf_q [0:3];
    logic [3:0] rf_d [0:3];
    logic [3:0] alu_op_q,    alu_op_d;
    logic [3:0] alu_a_q,     alu_a_d;
    logic [3:0] alu_b_q,     alu_b_d;
    logic       alu_cin_q,   alu_cin_d;
    logic       alu_rcin_q,  alu_rcin_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [3:0] rsp_data_q,  rsp_data_d;
    logic [3:0] rsp_flags_q, rsp_flags_d;

    logic       accept_s;
    logic       capture_s;
    logic [3:0] alu_flags_s;

    // cmd_ready_q is low out of reset so nothing is accepted at the release edge.
    assign accept_s    = (state_q == ST_IDLE) && cmd_ready_q && cmd_valid;
    assign capture_s   = (state_q == ST_EXEC) && (cnt_q == 4'd0);
    assign alu_flags_s = {alu_ovf, alu_zero, alu_rcout, alu_cout};

    // Next-state, ALU drive, capture and register-file write logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dst_d       = dst_q;
        flags_d     = flags_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cin_d   = alu_cin_q;
        alu_rcin_d  = alu_rcin_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    // Operands come from the array before this edge's writes.
                    alu_op_d   = cmd_op;
                    alu_a_d    = rf_q[cmd_srca];
                    alu_b_d    = rf_q[cmd_srcb];
                    alu_cin_d  = cmd_chain ? flags_q[0] : cmd_cin;
                    alu_rcin_d = cmd_chain ? flags_q[1] : cmd_rcin;
                    dst_d      = cmd_dst;
                    cnt_d      = CNT_LOAD;
                    state_d    = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (capture_s) begin
                    rsp_data_d  = alu_out;
                    rsp_flags_d = alu_flags_s;
                    flags_d     = alu_flags_s;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // ALU writeback has priority over an immediate load to the same entry.
        for (int i = 0; i < 4; i++) begin
            if (capture_s && (dst_q == 2'(i))) begin
                rf_d[i] = alu_out;
            end else if (ld_valid && (ld_dst == 2'(i))) begin
                rf_d[i] = ld_data;
            end else begin
                rf_d[i] = rf_q[i];
            end
        end

        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // State, register file and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            dst_q       <= 2'd0;
            flags_q     <= FLAG_RST;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= 4'd0;
            end
            alu_op_q    <= 4'd0;
            alu_a_q     <= 4'd0;
            alu_b_q     <= 4'd0;
            alu_cin_q   <= 1'b0;
            alu_rcin_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 4'd0;
            rsp_flags_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dst_q       <= dst_d;
            flags_q     <= flags_d;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= rf_d[i];
            end
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            alu_rcin_q  <= alu_rcin_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;
    assign alu_rcin  = alu_rcin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign rd_data   = rf_q[rd_sel];

endmodule

// File: tb/tb_alu4_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu4_sequencer
//
// Self-checking bench for alu4_sequencer. A stub ALU sits on the alu_* ports;
// its output can be corrupted by an xor "glitch" during EXEC, and the glitch
// is removed one cycle before the capture edge. A reference model (register
// array + flags) predicts operands, carries, responses and register contents.
// -----------------------------------------------------------------------------
module tb_alu4_sequencer;

    localparam int unsigned LAT  = 3;
    localparam logic [3:0]  FRST = 4'b0110;   // {ovf=0, zero=1, rc=1, c=0}

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = 4'd0;
    logic [1:0] cmd_srca = 2'd0, cmd_srcb = 2'd0, cmd_dst = 2'd0;
    logic       cmd_chain = 1'b0, cmd_cin = 1'b0, cmd_rcin = 1'b0;
    logic       ld_valid = 1'b0;
    logic [1:0] ld_dst = 2'd0;
    logic [3:0] ld_data = 4'd0;
    logic [3:0] alu_op, alu_a, alu_b;
    logic       alu_cin, alu_rcin;
    logic [3:0] alu_out;
    logic       alu_cout, alu_rcout, alu_ovf, alu_zero;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data, rsp_flags;
    logic [1:0] rd_sel = 2'd0;
    logic [3:0] rd_data;

    logic [7:0] glitch = 8'd0;
    logic [7:0] stub_s;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [3:0] m_rf [4];
    logic [3:0] m_flags;

    always #5 clk = ~clk;

    alu4_sequencer #(.ALU_LAT(LAT), .FLAG_RST(FRST)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_dst(cmd_dst),
        .cmd_chain(cmd_chain), .cmd_cin(cmd_cin), .cmd_rcin(cmd_rcin),
        .ld_valid(ld_valid), .ld_dst(ld_dst), .ld_data(ld_data),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cin(alu_cin), .alu_rcin(alu_rcin),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_rcout(alu_rcout),
        .alu_ovf(alu_ovf), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .rd_sel(rd_sel), .rd_data(rd_data)
    );

    // Stub ALU: returns {ovf, zero, rc, c, result}.
    function automatic logic [7:0] stub_alu(input logic [3:0] op, input logic [3:0] a,
                                            input logic [3:0] b, input logic cin,
                                            input logic rcin);
        logic [4:0] s;
        logic [3:0] r;
        logic       c, rc, v;
        s = 5'd0; r = 4'd0; c = 1'b0; rc = rcin; v = 1'b0;
        case (op)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
                r = s[3:0]; c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'd2: begin
                s = {1'b0, a} + {1'b0, ~b} + {4'd0, cin};
                r = s[3:0]; c = s[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            4'd3: begin
                r = {a[2:0], rcin}; rc = a[3];
            end
            4'd4: r = a ^ b;
            default: r = a & b;
        endcase
        return {v, (r == 4'd0), rc, c, r};
    endfunction

    always_comb stub_s = stub_alu(alu_op, alu_a, alu_b, alu_cin, alu_rcin) ^ glitch;
    assign {alu_ovf, alu_zero, alu_rcout, alu_cout, alu_out} = stub_s;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
        m_flags = FRST;
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), {4'd0, rd_data}, {4'd0, m_rf[i]});
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) tick();
        check("cmd_ready_wait", {7'd0, cmd_ready}, 8'd1);
    endtask

    task automatic do_load(input logic [1:0] d, input logic [3:0] v);
        ld_valid = 1'b1; ld_dst = d; ld_data = v;
        tick();
        ld_valid = 1'b0;
        m_rf[d] = v;
        rd_sel = d;
        #1;
        check("load_rd", {4'd0, rd_data}, {4'd0, v});
    endtask

    // One complete command: accept, EXEC with glitches, capture, response.
    task automatic do_cmd(input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                          input logic [1:0] dst, input logic chain, input logic cin,
                          input logic rcin, input int hold, input logic acc_ld,
                          input logic cap_ld, input logic [1:0] lddst,
                          input logic [3:0] lddata);
        logic [3:0] ea, eb;
        logic       ec, erc;
        logic [7:0] er;
        wait_ready();
        cmd_op = op; cmd_srca = sa; cmd_srcb = sb; cmd_dst = dst;
        cmd_chain = chain; cmd_cin = cin; cmd_rcin = rcin; cmd_valid = 1'b1;
        ea  = m_rf[sa];
        eb  = m_rf[sb];
        ec  = chain ? m_flags[0] : cin;
        erc = chain ? m_flags[1] : rcin;
        er  = stub_alu(op, ea, eb, ec, erc);
        if (acc_ld) begin
            ld_valid = 1'b1; ld_dst = lddst; ld_data = lddata;
        end
        tick();   // accept edge
        cmd_valid = 1'b0; ld_valid = 1'b0;
        if (acc_ld) m_rf[lddst] = lddata;
        check("acc_alu_op", {4'd0, alu_op}, {4'd0, op});
        check("acc_alu_a", {4'd0, alu_a}, {4'd0, ea});
        check("acc_alu_b", {4'd0, alu_b}, {4'd0, eb});
        check("acc_alu_cin", {7'd0, alu_cin}, {7'd0, ec});
        check("acc_alu_rcin", {7'd0, alu_rcin}, {7'd0, erc});
        check("acc_cmd_ready", {7'd0, cmd_ready}, 8'd0);
        if (LAT > 1) glitch = 8'($urandom_range(1, 255));
        for (int j = 1; j < int'(LAT); j++) begin
            tick();
            check("exec_alu_a", {4'd0, alu_a}, {4'd0, ea});
            check("exec_alu_b", {4'd0, alu_b}, {4'd0, eb});
            check("exec_rsp_valid", {7'd0, rsp_valid}, 8'd0);
            if (j == int'(LAT) - 1) glitch = 8'd0;
        end
        if (cap_ld) begin
            ld_valid = 1'b1; ld_dst = lddst; ld_data = lddata;
        end
        tick();   // capture edge
        ld_valid = 1'b0;
        if (cap_ld) m_rf[lddst] = lddata;
        m_rf[dst] = er[3:0];
        m_flags   = er[7:4];
        check("cap_rsp_valid", {7'd0, rsp_valid}, 8'd1);
        check("cap_rsp_data", {4'd0, rsp_data}, {4'd0, er[3:0]});
        check("cap_rsp_flags", {4'd0, rsp_flags}, {4'd0, er[7:4]});
        check_rf("cap_rf");
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_rsp_valid", {7'd0, rsp_valid}, 8'd1);
            check("hold_rsp_data", {4'd0, rsp_data}, {4'd0, er[3:0]});
            check("hold_cmd_ready", {7'd0, cmd_ready}, 8'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("done_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        check("done_cmd_ready", {7'd0, cmd_ready}, 8'd1);
        check("done_alu_a_kept", {4'd0, alu_a}, {4'd0, ea});
    endtask

    initial begin
        model_reset();

        // Power-on reset.
        tick();
        tick();
        check("rst_cmd_ready", {7'd0, cmd_ready}, 8'd0);
        check("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        check("rst_alu_a", {4'd0, alu_a}, 8'd0);
        check("rst_rsp_data", {4'd0, rsp_data}, 8'd0);
        check_rf("rst_rf");
        rst = 1'b0;
        check("rel_cmd_ready_low", {7'd0, cmd_ready}, 8'd0);
        tick();
        check("rel_cmd_ready_high", {7'd0, cmd_ready}, 8'd1);

        // Chain right after reset uses FLAG_RST carries (c=0, rc=1).
        do_cmd(4'd3, 2'd0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd0, 4'd0);

        // Basic add: 5 + 9 + 1 = F.
        do_load(2'd0, 4'd5);
        do_load(2'd1, 4'd9);
        do_cmd(4'd1, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 2'd0, 4'd0);

        // Chain: F + 1 -> 0 with carry, then 0 + 0 + c -> 1.
        do_load(2'd0, 4'hF);
        do_load(2'd1, 4'h1);
        do_load(2'd3, 4'h0);
        do_cmd(4'd1, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2'd0, 4'd0);
        do_cmd(4'd1, 2'd2, 2'd3, 2'd1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2'd0, 4'd0);

        // Backpressure for 10 cycles.
        do_cmd(4'd4, 2'd0, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 2'd0, 4'd0);

        // Write collisions at the capture edge: same dst, then different dst.
        do_cmd(4'd1, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 2'd2, 4'hA);
        do_cmd(4'd1, 2'd1, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 2'd0, 4'h6);

        // Load on the accept edge to srca: old operand used; srca==dst too.
        do_cmd(4'd2, 2'd0, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 2'd0, 4'h3);

        // Randomized commands.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) do_load(2'($urandom), 4'($urandom));
            do_cmd(4'($urandom_range(0, 5)), 2'($urandom), 2'($urandom), 2'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                   2'($urandom), 4'($urandom));
        end

        // Reset asserted in the middle of EXEC.
        wait_ready();
        cmd_op = 4'd1; cmd_srca = 2'd1; cmd_srcb = 2'd2; cmd_dst = 2'd3;
        cmd_chain = 1'b0; cmd_cin = 1'b1; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        glitch = 8'h5A;
        tick();
        rst = 1'b1;
        glitch = 8'd0;
        model_reset();
        #1;
        check("mid_rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        check("mid_rst_cmd_ready", {7'd0, cmd_ready}, 8'd0);
        check("mid_rst_alu_a", {4'd0, alu_a}, 8'd0);
        check_rf("mid_rst_rf");
        tick();
        tick();
        check("mid_rst_hold_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        rst = 1'b0;
        tick();
        check("mid_rel_cmd_ready", {7'd0, cmd_ready}, 8'd1);
        check("mid_rel_rsp_valid", {7'd0, rsp_valid}, 8'd0);

        // Flags restored to FLAG_RST: chained rotate sees rc=1, c=0.
        do_cmd(4'd3, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
